// File: rtl/mem_bus_arbiter.sv
// Shares one tagged memory bus between I-cache and D-cache and steers load tags back to their owner.
// Optional grant/conflict counters are enabled with `define MEM_ARB_STATS_EN.
module mem_bus_arbiter #(
    parameter int XLEN       = 32,
    parameter int NUM_TAGS   = 16,
    parameter int MAX_STARVE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      icache_command,
    input  logic [XLEN-1:0] icache_addr,
    input  logic [63:0]     icache_data,
    input  logic [1:0]      icache_size,
    input  logic [1:0]      dcache_command,
    input  logic [XLEN-1:0] dcache_addr,
    input  logic [63:0]     dcache_data,
    input  logic [1:0]      dcache_size,
    output logic [3:0]      icache_response,
    output logic [3:0]      dcache_response,
    output logic [3:0]      icache_tag,
    output logic [3:0]      dcache_tag,
    output logic [63:0]     mem_data_out,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]     stat_igrant,
    output logic [31:0]     stat_dgrant,
    output logic [31:0]     stat_conflict,
`endif
    output logic            arb_err
);

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int         SW       = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    logic                i_req, d_req, grant_i, grant_d;
    logic                accepted, alloc, ret_hit;
    logic [SW-1:0]       starve_q, starve_d;
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;
    logic                err_q, err_d;

    assign i_req   = icache_command != BUS_NONE;
    assign d_req   = dcache_command != BUS_NONE;
    assign grant_i = i_req && (!d_req || starve_q == STARVE_MAX);
    assign grant_d = d_req && !grant_i;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = '0;
        icache_response  = '0;
        dcache_response  = '0;
        unique case (1'b1)
            grant_i: begin
                proc2mem_command = icache_command;
                proc2mem_addr    = icache_addr;
                proc2mem_data    = icache_data;
                proc2mem_size    = icache_size;
                icache_response  = mem2proc_response;
            end
            grant_d: begin
                proc2mem_command = dcache_command;
                proc2mem_addr    = dcache_addr;
                proc2mem_data    = dcache_data;
                proc2mem_size    = dcache_size;
                dcache_response  = mem2proc_response;
            end
            default: ;
        endcase
    end

    assign accepted     = (grant_i || grant_d) && mem2proc_response != '0;
    assign alloc        = accepted && proc2mem_command == BUS_LOAD;
    assign ret_hit      = mem2proc_tag != '0 && valid_q[mem2proc_tag];
    assign icache_tag   = (ret_hit && !owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    assign dcache_tag   = (ret_hit && owner_q[mem2proc_tag]) ? mem2proc_tag : 4'd0;
    assign mem_data_out = mem2proc_data;
    assign arb_err      = err_q;

    always_comb begin
        starve_d = starve_q;
        if (!i_req || grant_i) begin
            starve_d = '0;
        end else if (grant_d && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // The return clears before the allocate so a same-edge reuse of a tag is legal.
    always_comb begin
        valid_d = valid_q;
        owner_d = owner_q;
        err_d   = err_q;
        if (mem2proc_tag != '0) begin
            if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
            else         err_d = 1'b1;
        end
        if (alloc) begin
            if (valid_d[mem2proc_response]) err_d = 1'b1;
            valid_d[mem2proc_response] = 1'b1;
            owner_d[mem2proc_response] = grant_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_q <= '0;
            valid_q  <= '0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] igrant_q, dgrant_q, conflict_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            igrant_q   <= '0;
            dgrant_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (accepted && grant_i) igrant_q <= igrant_q + 32'd1;
            if (accepted && grant_d) dgrant_q <= dgrant_q + 32'd1;
            if (i_req && d_req)      conflict_q <= conflict_q + 32'd1;
        end
    end

    assign stat_igrant   = igrant_q;
    assign stat_dgrant   = dgrant_q;
    assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed checks of mem_bus_arbiter against a tag-ownership reference model.
// Stats outputs are checked when MEM_ARB_STATS_EN is defined.
module tb_mem_bus_arbiter;

    localparam logic [1:0] NONE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam int         MAXS  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icache_command, dcache_command;
    logic [31:0] icache_addr, dcache_addr;
    logic [63:0] icache_data, dcache_data;
    logic [1:0]  icache_size, dcache_size;
    logic [3:0]  icache_response, dcache_response;
    logic [3:0]  icache_tag, dcache_tag;
    logic [63:0] mem_data_out;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic        arb_err;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_igrant, stat_dgrant, stat_conflict;
`endif

    always #5 clock = ~clock;

    mem_bus_arbiter dut (
        .clock(clock),
        .reset(reset),
        .icache_command(icache_command),
        .icache_addr(icache_addr),
        .icache_data(icache_data),
        .icache_size(icache_size),
        .dcache_command(dcache_command),
        .dcache_addr(dcache_addr),
        .dcache_data(dcache_data),
        .dcache_size(dcache_size),
        .icache_response(icache_response),
        .dcache_response(dcache_response),
        .icache_tag(icache_tag),
        .dcache_tag(dcache_tag),
        .mem_data_out(mem_data_out),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
`ifdef MEM_ARB_STATS_EN
        .stat_igrant(stat_igrant),
        .stat_dgrant(stat_dgrant),
        .stat_conflict(stat_conflict),
`endif
        .arb_err(arb_err)
    );

    int checks = 0;
    int fails  = 0;

    // Reference state: owner per tag (-1 free, 0 I-cache, 1 D-cache)
    int          own[16];
    int          waits;
    bit          err;
    int unsigned n_i, n_d, n_c;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < 16; t++) own[t] = -1;
        waits = 0;
        err   = 1'b0;
        n_i   = 0;
        n_d   = 0;
        n_c   = 0;
    endtask

    task automatic check_stats();
`ifdef MEM_ARB_STATS_EN
        check("stat_igrant", {32'd0, stat_igrant}, {32'd0, n_i});
        check("stat_dgrant", {32'd0, stat_dgrant}, {32'd0, n_d});
        check("stat_conflict", {32'd0, stat_conflict}, {32'd0, n_c});
`endif
    endtask

    task automatic step(input logic [1:0] ic, input logic [31:0] ia,
                        input logic [1:0] dc, input logic [31:0] da,
                        input logic [3:0] rsp, input logic [3:0] rt);
        bit          ir, dr, gi, gd;
        int          who;
        logic [63:0] md;
        icache_command    = ic;
        icache_addr       = ia;
        icache_data       = {32'h1111_0000, ia};
        icache_size       = 2'd2;
        dcache_command    = dc;
        dcache_addr       = da;
        dcache_data       = {32'h2222_0000, da};
        dcache_size       = 2'd3;
        mem2proc_response = rsp;
        mem2proc_tag      = rt;
        md                = {$urandom, $urandom};
        mem2proc_data     = md;
        #1;
        ir  = ic != NONE;
        dr  = dc != NONE;
        gi  = ir && (!dr || waits >= MAXS);
        gd  = dr && !gi;
        who = (rt != 0) ? own[rt] : -1;
        check("icache_response", 64'(icache_response), gi ? 64'(rsp) : 64'd0);
        check("dcache_response", 64'(dcache_response), gd ? 64'(rsp) : 64'd0);
        check("proc2mem_command", 64'(proc2mem_command),
              gi ? 64'(ic) : gd ? 64'(dc) : 64'd0);
        if (gi || gd) begin
            check("proc2mem_addr", 64'(proc2mem_addr), gi ? 64'(ia) : 64'(da));
            check("proc2mem_data", proc2mem_data,
                  gi ? {32'h1111_0000, ia} : {32'h2222_0000, da});
            check("proc2mem_size", 64'(proc2mem_size), gi ? 64'd2 : 64'd3);
        end
        check("icache_tag", 64'(icache_tag), who == 0 ? 64'(rt) : 64'd0);
        check("dcache_tag", 64'(dcache_tag), who == 1 ? 64'(rt) : 64'd0);
        check("mem_data_out", mem_data_out, md);
        check("arb_err", 64'(arb_err), 64'(err));
        check_stats();
        @(posedge clock);
        if (rt != 0) begin
            if (who < 0) err = 1'b1;
            own[rt] = -1;
        end
        if ((gi || gd) && rsp != 0) begin
            if (gi) n_i++;
            else    n_d++;
            if ((gi ? ic : dc) == LOAD) begin
                if (own[rsp] >= 0) err = 1'b1;
                own[rsp] = gi ? 0 : 1;
            end
        end
        if (ir && dr) n_c++;
        if (!ir || gi) waits = 0;
        else if (gd && waits < MAXS) waits++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        icache_command    = NONE;
        dcache_command    = NONE;
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd0;
        reset             = 1'b0;
        #1;
        model_clear();
        check("reset arb_err", 64'(arb_err), 64'd0);
        check("reset icache_tag", 64'(icache_tag), 64'd0);
        check("reset dcache_tag", 64'(dcache_tag), 64'd0);
        check_stats();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    function automatic logic [3:0] pick_tag();
        logic [3:0] q[$];
        for (int t = 1; t < 16; t++) if (own[t] >= 0) q.push_back(4'(t));
        if (q.size() != 0 && $urandom_range(0, 1) == 1)
            return q[$urandom_range(0, q.size() - 1)];
        if ($urandom_range(0, 2) != 0) return 4'd0;
        return 4'($urandom_range(1, 15));
    endfunction

    initial begin
        reset = 1'b1;
        model_clear();
        @(negedge clock);
        do_reset();

        step(LOAD, 32'h100, NONE, 32'h0, 4'd3, 4'd0);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd3);

        for (int k = 0; k < 10; k++) begin
            step(STORE, 32'h400 + 32'(k), STORE, 32'h800 + 32'(k), 4'd1, 4'd0);
        end

        step(NONE, 32'h0, STORE, 32'h200, 4'd5, 4'd0);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd5);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd0);
        do_reset();

        step(LOAD, 32'h10, NONE, 32'h0, 4'd7, 4'd0);
        step(NONE, 32'h0, LOAD, 32'h20, 4'd8, 4'd0);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd8);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd7);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd0);

        step(LOAD, 32'h30, NONE, 32'h0, 4'd2, 4'd0);
        step(NONE, 32'h0, LOAD, 32'h40, 4'd2, 4'd2);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd2);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd0);

        step(LOAD, 32'h50, NONE, 32'h0, 4'd4, 4'd0);
        step(NONE, 32'h0, LOAD, 32'h60, 4'd6, 4'd0);
        do_reset();
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd4);
        step(NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd0);
        do_reset();

        for (int n = 0; n < 800; n++) begin
            logic [3:0] rsp;
            rsp = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step(2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 2)),
                 $urandom, rsp, pick_tag());
            if (n % 200 == 199) do_reset();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
